// File: rtl/ulpi_reg_ctrl_pkg.sv
// ulpi_reg_ctrl_pkg
//   Shared definitions for the ULPI register/NOPID command path.
//   Contents: FSM state codes, transaction kinds, TX CMD encodings, and
//   small helpers for command-byte construction and saturating counting.
package ulpi_reg_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CMD   = 4'd1,
    ST_WDATA = 4'd2,
    ST_WSTOP = 4'd3,
    ST_RTURN = 4'd4,
    ST_RDATA = 4'd5,
    ST_RWAIT = 4'd6,
    ST_NHOLD = 4'd7,
    ST_NSTOP = 4'd8,
    ST_ABORT = 4'd9
  } state_e;

  // Bit 1 clear means the transaction belongs to port A.
  typedef enum logic [1:0] {
    TK_A_WRITE = 2'd0,
    TK_A_NOPID = 2'd1,
    TK_B_WRITE = 2'd2,
    TK_B_READ  = 2'd3
  } txn_kind_e;

  localparam logic [1:0] CMD_REGW_PFX = 2'b10;
  localparam logic [1:0] CMD_REGR_PFX = 2'b11;
  localparam logic [7:0] CMD_NOPID    = 8'h40;

  // TX CMD byte for a port-B register access.
  function automatic logic [7:0] b_cmd_byte(input logic rnw, input logic [5:0] addr);
    return {(rnw ? CMD_REGR_PFX : CMD_REGW_PFX), addr};
  endfunction

  // Increment that sticks at 0xFF.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ulpi_reg_ctrl
//   ULPI link-side command sequencer for register writes/reads and NOPID
//   (chirp) transmits, shared between port A (line-state FSM) and port B
//   (core config). Retries a transaction after a PHY abort and flags an
//   error once the retry budget is spent.
// Ports
//   clock, reset_n               : 60 MHz ULPI clock, async active-low reset
//   ulpi_dir_i/nxt_i/dat_i       : PHY side inputs
//   ulpi_dat_o, ulpi_stp_o       : link side outputs (registered)
//   tx_busy_i                    : packet transmitter owns the bus
//   a_write_i/nopid_i/stop_i,
//   a_addr_i/data_i, a_done_o    : port A requests and completion pulse
//   b_req_i/rnw_i/addr_i/data_i,
//   b_ack_o, b_rdata_o           : port B request, completion pulse, read data
//   err_o, busy_o, abort_cnt_o   : retry-exhausted flag, activity, abort count
module ulpi_reg_ctrl
  import ulpi_reg_ctrl_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic [7:0] ulpi_dat_i,
  output logic [7:0] ulpi_dat_o,
  output logic       ulpi_stp_o,
  input  logic       tx_busy_i,
  input  logic       a_write_i,
  input  logic       a_nopid_i,
  input  logic       a_stop_i,
  input  logic [7:0] a_addr_i,
  input  logic [7:0] a_data_i,
  output logic       a_done_o,
  input  logic       b_req_i,
  input  logic       b_rnw_i,
  input  logic [5:0] b_addr_i,
  input  logic [7:0] b_data_i,
  output logic       b_ack_o,
  output logic [7:0] b_rdata_o,
  output logic       err_o,
  output logic       busy_o,
  output logic [7:0] abort_cnt_o
);

  localparam logic [7:0] RETRY_LIMIT = RETRY_MAX[7:0];

  state_e    state_q, state_d;
  txn_kind_e kind_q, kind_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d;
  logic       last_a_q, last_a_d;
  logic [7:0] retry_q, retry_d;
  logic       err_pend_q, err_pend_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] dat_q, dat_d;
  logic       stp_q, stp_d;
  logic       done_q, done_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       abort_s;
  logic       finish_s;

  // Next-state, arbitration, retry bookkeeping and completion pulses.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    last_a_d    = last_a_q;
    retry_d     = retry_q;
    err_pend_d  = err_pend_q;
    abort_cnt_d = abort_cnt_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    abort_s     = 1'b0;
    finish_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        retry_d    = 8'd0;
        err_pend_d = 1'b0;
        // A pulse cycle is skipped: the requester still holds its level then.
        if (!ulpi_dir_i && !tx_busy_i && !done_q && !ack_q) begin
          if (a_nopid_i) begin
            kind_d  = TK_A_NOPID;
            cmd_d   = CMD_NOPID;
            state_d = ST_CMD;
          end else if (a_write_i && (!b_req_i || !last_a_q)) begin
            kind_d   = TK_A_WRITE;
            cmd_d    = a_addr_i;
            wdata_d  = a_data_i;
            last_a_d = 1'b1;
            state_d  = ST_CMD;
          end else if (b_req_i) begin
            kind_d   = b_rnw_i ? TK_B_READ : TK_B_WRITE;
            cmd_d    = b_cmd_byte(b_rnw_i, b_addr_i);
            wdata_d  = b_data_i;
            last_a_d = 1'b0;
            state_d  = ST_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ulpi_dir_i) begin
          abort_s = 1'b1;
        end else if (ulpi_nxt_i) begin
          case (kind_q)
            TK_A_NOPID: state_d = ST_NHOLD;
            TK_B_READ:  state_d = ST_RTURN;
            default:    state_d = ST_WDATA;
          endcase
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_WDATA: begin
        if (ulpi_dir_i) begin
          abort_s = 1'b1;
        end else if (ulpi_nxt_i) begin
          state_d = ST_WSTOP;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WSTOP: begin
        finish_s = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_RTURN: begin
        state_d = ulpi_dir_i ? ST_RDATA : ST_RTURN;
      end
      ST_RDATA: begin
        // Anything but a clean data cycle means the PHY took the bus back.
        if (ulpi_dir_i && !ulpi_nxt_i) begin
          rdata_d = ulpi_dat_i;
          state_d = ST_RWAIT;
        end else begin
          abort_s = 1'b1;
        end
      end
      ST_RWAIT: begin
        if (!ulpi_dir_i) begin
          finish_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      ST_NHOLD: begin
        state_d = a_stop_i ? ST_NSTOP : ST_NHOLD;
      end
      ST_NSTOP: begin
        finish_s = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ABORT: begin
        if (!ulpi_dir_i && !tx_busy_i) begin
          if (err_pend_q) begin
            finish_s = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_CMD;
          end
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_s) begin
      state_d     = ST_ABORT;
      abort_cnt_d = sat_inc8(abort_cnt_q);
      // The abort that finds the budget used up turns into an error completion.
      if (retry_q == RETRY_LIMIT) begin
        err_pend_d = 1'b1;
      end else begin
        retry_d = retry_q + 8'd1;
      end
    end else begin
      abort_cnt_d = abort_cnt_q;
    end

    if (finish_s) begin
      done_d = ~kind_q[1];
      ack_d  = kind_q[1];
      err_d  = err_pend_q;
    end else begin
      done_d = 1'b0;
      ack_d  = 1'b0;
      err_d  = 1'b0;
    end
  end

  // Bus outputs decoded from the upcoming state so they leave a flop.
  always_comb begin
    dat_d  = 8'h00;
    stp_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_CMD:   dat_d = cmd_d;
      ST_WDATA: dat_d = wdata_d;
      ST_WSTOP: stp_d = 1'b1;
      ST_NSTOP: stp_d = 1'b1;
      default:  dat_d = 8'h00;
    endcase
  end

  // State and output registers; reset clears the bus immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= TK_A_WRITE;
      cmd_q       <= 8'h00;
      wdata_q     <= 8'h00;
      last_a_q    <= 1'b0;
      retry_q     <= 8'd0;
      err_pend_q  <= 1'b0;
      abort_cnt_q <= 8'd0;
      rdata_q     <= 8'h00;
      dat_q       <= 8'h00;
      stp_q       <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      last_a_q    <= last_a_d;
      retry_q     <= retry_d;
      err_pend_q  <= err_pend_d;
      abort_cnt_q <= abort_cnt_d;
      rdata_q     <= rdata_d;
      dat_q       <= dat_d;
      stp_q       <= stp_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign ulpi_dat_o  = dat_q;
  assign ulpi_stp_o  = stp_q;
  assign a_done_o    = done_q;
  assign b_ack_o     = ack_q;
  assign b_rdata_o   = rdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign abort_cnt_o = abort_cnt_q;

endmodule
